// File: rtl/stack_pkg.sv
// Shared types and helpers for the param_stack LIFO: count-width sizing and
// the stack operation decoded from the {push, pop} request pair.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_PUSH    = 2'b10,
    OP_POP     = 2'b01,
    OP_REPLACE = 2'b11
  } op_e;

  // Bits needed to hold every occupancy value 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/stack_ptr.sv
// Saturating occupancy counter for param_stack; flags dropped pushes and empty pops.
// PARAM_STACK_HWM_EN exposes the next-state count for the high-water mark.
module stack_ptr
  import stack_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          hold_i,
  output logic [CW-1:0] count_o,
`ifdef PARAM_STACK_HWM_EN
  output logic [CW-1:0] count_next_o,
`endif
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_evt_o,
  output logic          udf_evt_o
);

  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
`ifdef PARAM_STACK_HWM_EN
  assign count_next_o = count_d;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    count_d   = count_q;
    ovf_evt_o = 1'b0;
    udf_evt_o = 1'b0;
    if (!hold_i) begin
      if (inc_i && !dec_i) begin
        if (full_o) ovf_evt_o = 1'b1;
        else        count_d   = count_q + CW'(1);
      end else if (dec_i && !inc_i) begin
        if (empty_o) udf_evt_o = 1'b1;
        else         count_d   = count_q - CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with replace/bypass, registered pop data and sticky errors.
// Define PARAM_STACK_HWM_EN to add the hwm (high-water mark) output.
module param_stack
  import stack_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clear_err,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
`ifdef PARAM_STACK_HWM_EN
  output logic [CW-1:0]    hwm,
`endif
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  op_e              op;
  logic             ovf_evt, udf_evt;
  logic [AW-1:0]    wr_idx, top_idx, mem_widx;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_wdata, pop_data_q, pop_data_d;
  logic             mem_we, pop_valid_q, pop_valid_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
`ifdef PARAM_STACK_HWM_EN
  logic [CW-1:0]    count_next, hwm_q, hwm_d;
`endif

  assign op = decode_op(push, pop);

  stack_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk          (clk),
    .reset        (reset),
    .inc_i        (op == OP_PUSH),
    .dec_i        (op == OP_POP),
    .hold_i       (op == OP_REPLACE),
    .count_o      (count),
`ifdef PARAM_STACK_HWM_EN
    .count_next_o (count_next),
`endif
    .full_o       (full),
    .empty_o      (empty),
    .ovf_evt_o    (ovf_evt),
    .udf_evt_o    (udf_evt)
  );

  assign wr_idx  = AW'(count);
  assign top_idx = AW'(count - CW'(1));
  assign top     = empty ? '0 : mem_q[top_idx];

  always_comb begin
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_widx    = wr_idx;
    mem_wdata   = push_data;
    case (op)
      OP_PUSH: mem_we = !full;
      OP_POP: begin
        if (!empty) begin
          pop_data_d  = top;
          pop_valid_d = 1'b1;
        end
      end
      OP_REPLACE: begin
        // On an empty stack the pushed word bypasses straight to pop_data.
        pop_valid_d = 1'b1;
        if (empty) begin
          pop_data_d = push_data;
        end else begin
          pop_data_d = top;
          mem_we     = 1'b1;
          mem_widx   = top_idx;
        end
      end
      default: ;
    endcase
    overflow_d  = ovf_evt | (overflow_q  & ~clear_err);
    underflow_d = udf_evt | (underflow_q & ~clear_err);
  end

  // NOTE: the storage array is deliberately reset, so top reads 0 and no stale
  // word can reappear after reset; this costs a reset on every flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (mem_we) mem_q[mem_widx] <= mem_wdata;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef PARAM_STACK_HWM_EN
  // A rise in the same cycle takes precedence over clear_err.
  always_comb begin
    hwm_d = hwm_q;
    if (count_next > hwm_q) hwm_d = count_next;
    else if (clear_err)     hwm_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule
